display_scan_sequencer: RTL and testbench

//  Scan controller for the 8-digit 7-segment display chain. Takes the packed BCD

---
 rtl/display_scan_sequencer_if.sv | 10 +
 rtl/display_scan_sequencer.sv | 127 ++++++++++++
 tb/tb_display_scan_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_scan_sequencer_if.sv
// Word channel from the scan sequencer to the 74HC595 serial shifter.
// A word transfers on each rising clock edge where tx_valid and tx_ready are both high.
interface display_scan_sequencer_if;
    logic        tx_valid;
    logic [15:0] tx_data;
    logic        tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/display_scan_sequencer.sv
// Scan controller for an 8-digit 7-segment chain: one {dp, seg, sel} word per digit,
// handed to the shifter and then held for a dwell time; new data is taken only at frame start.
module display_scan_sequencer #(
    parameter int DIGITS       = 8,
    parameter int DWELL_CYCLES = 50000,
    parameter int CNT_W        = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [31:0]                 data_bcd,
    input  logic                        data_valid,
    input  logic                        blank_lz,
    display_scan_sequencer_if.master    tx,
    output logic                        frame_done,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, DWELL} state_t;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(DIGITS - 1);

    state_t           state, state_nxt;
    logic [31:0]      shadow, active;
    logic [2:0]       digit_idx;
    logic [CNT_W-1:0] dwell_cnt;
    logic [15:0]      tx_data_q;
    logic             dwell_end;

    logic [31:0]      src;
    logic [3:0]       nibble;
    logic             upper_zero;
    logic             blank;
    logic [6:0]       seg;
    logic [7:0]       sel;
    logic [15:0]      word_nxt;

    // Active-low segments, bit order {g,f,e,d,c,b,a}; anything above 9 shows a dash.
    function automatic logic [6:0] seg_of(input logic [3:0] n);
        case (n)
            4'd0:    seg_of = 7'h40;
            4'd1:    seg_of = 7'h79;
            4'd2:    seg_of = 7'h24;
            4'd3:    seg_of = 7'h30;
            4'd4:    seg_of = 7'h19;
            4'd5:    seg_of = 7'h12;
            4'd6:    seg_of = 7'h02;
            4'd7:    seg_of = 7'h78;
            4'd8:    seg_of = 7'h00;
            4'd9:    seg_of = 7'h10;
            default: seg_of = 7'h3F;
        endcase
    endfunction

    assign dwell_end = (state == DWELL) && (dwell_cnt == DWELL_LAST);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en) state_nxt = LOAD;
            LOAD:    state_nxt = SEND;
            SEND:    if (tx.tx_ready) state_nxt = DWELL;
            DWELL:   if (dwell_end) state_nxt = en ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Digit 0 is built from the shadow directly, since that is what active becomes this cycle.
    always_comb begin
        src        = (digit_idx == 3'd0) ? shadow : active;
        nibble     = src[{digit_idx, 2'b00} +: 4];
        upper_zero = 1'b1;
        for (int j = 0; j < 8; j++) begin
            if (j >= int'(digit_idx) && j < DIGITS && src[j*4 +: 4] != 4'd0)
                upper_zero = 1'b0;
        end
        blank          = blank_lz && (digit_idx != 3'd0) && upper_zero;
        seg            = blank ? 7'h7F : seg_of(nibble);
        sel            = 8'hFF;
        sel[digit_idx] = 1'b0;
        word_nxt       = {1'b1, seg, sel};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shadow     <= '0;
            active     <= '0;
            digit_idx  <= '0;
            dwell_cnt  <= '0;
            tx_data_q  <= 16'hFFFF;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            frame_done <= 1'b0;
            if (data_valid)
                shadow <= data_bcd;
            case (state)
                LOAD: begin
                    tx_data_q <= word_nxt;
                    if (digit_idx == 3'd0)
                        active <= shadow;
                end
                SEND:
                    dwell_cnt <= '0;
                DWELL: begin
                    dwell_cnt <= dwell_cnt + 1'b1;
                    if (dwell_end) begin
                        dwell_cnt  <= '0;
                        frame_done <= (digit_idx == LAST_DIGIT);
                        digit_idx  <= (digit_idx == LAST_DIGIT) ? 3'd0 : digit_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign tx.tx_valid = (state == SEND);
    assign tx.tx_data  = tx_data_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_display_scan_sequencer.sv
// Directed bench for display_scan_sequencer with DWELL_CYCLES=4 and all 8 digits;
// expected words are hand-computed {dp, seg, sel} values.
module tb_display_scan_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [31:0] data_bcd = '0;
    logic        data_valid = 1'b0;
    logic        blank_lz = 1'b0;
    logic        frame_done;
    logic        busy;

    int          tests = 0;
    int          fails = 0;

    logic [15:0] got [16];
    int          at [16];
    int          n_got;
    int          fd_seen;

    display_scan_sequencer_if tx_bus ();

    display_scan_sequencer #(
        .DIGITS       (8),
        .DWELL_CYCLES (4),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .data_bcd   (data_bcd),
        .data_valid (data_valid),
        .blank_lz   (blank_lz),
        .tx         (tx_bus),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input logic [31:0] value);
        reset = 1'b1;
        en = 1'b0;
        data_valid = 1'b0;
        blank_lz = 1'b0;
        tx_bus.tx_ready = 1'b1;
        tick(2);
        reset = 1'b0;
        data_bcd = value;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
    endtask

    // Records each rising tx_valid word and its cycle offset, plus frame_done pulses seen.
    task automatic collect(input int n);
        logic prev;
        int   cycle;
        prev = 1'b0;
        cycle = 0;
        n_got = 0;
        fd_seen = 0;
        while (n_got < n && cycle < 400) begin
            if (frame_done) fd_seen++;
            if (tx_bus.tx_valid && !prev) begin
                got[n_got] = tx_bus.tx_data;
                at[n_got] = cycle;
                n_got++;
            end
            prev = tx_bus.tx_valid;
            tick(1);
            cycle++;
        end
        tests++;
        if (n_got !== n) begin
            fails++;
            $display("FAIL collect_count: got %0d words, expected %0d", n_got, n);
        end
    endtask

    task automatic wait_valid(input string name);
        int c;
        c = 0;
        while (!tx_bus.tx_valid && c < 100) begin
            tick(1);
            c++;
        end
        tests++;
        if (tx_bus.tx_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s_wait_valid: tx_valid=%b after %0d cycles, expected 1", name, tx_bus.tx_valid, c);
        end
    endtask

    task automatic stop_scan();
        int c;
        en = 1'b0;
        c = 0;
        while (busy && c < 100) begin
            tick(1);
            c++;
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL stop_idle: busy=%b after %0d cycles, expected 0", busy, c);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tx_bus.tx_ready = 1'b1;
        tick(2);
        tests++;
        if (tx_bus.tx_valid !== 1'b0) begin
            fails++; $display("FAIL reset_tx_valid: got %b expected 0", tx_bus.tx_valid);
        end
        tests++;
        if (tx_bus.tx_data !== 16'hFFFF) begin
            fails++; $display("FAIL reset_tx_data: got %h expected ffff", tx_bus.tx_data);
        end
        tests++;
        if (frame_done !== 1'b0) begin
            fails++; $display("FAIL reset_frame_done: got %b expected 0", frame_done);
        end
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [9] = '{16'hB0FE, 16'hA4FD, 16'hF9FB, 16'hC0F7, 16'hC0EF,
                                   16'hC0DF, 16'hC0BF, 16'hC07F, 16'hB0FE};
        do_reset(32'h0000_0123);
        en = 1'b1;
        collect(9);
        tests++;
        if (at[0] !== 2) begin
            fails++; $display("FAIL basic_latency: first tx_valid at cycle %0d expected 2", at[0]);
        end
        for (int k = 0; k < 9; k++) begin
            tests++;
            if (got[k] !== exp_w[k]) begin
                fails++; $display("FAIL basic_word[%0d]: got %h expected %h", k, got[k], exp_w[k]);
            end
        end
        for (int k = 1; k < 9; k++) begin
            tests++;
            if (at[k] - at[k-1] !== 6) begin
                fails++; $display("FAIL basic_spacing[%0d]: got %0d expected 6", k, at[k] - at[k-1]);
            end
        end
        tests++;
        if (fd_seen !== 1) begin
            fails++; $display("FAIL basic_frame_done: got %0d pulses expected 1", fd_seen);
        end
        stop_scan();
    endtask

    task automatic test_blank_lz();
        logic [15:0] exp_w [8] = '{16'hB0FE, 16'hA4FD, 16'hF9FB, 16'hFFF7, 16'hFFEF,
                                   16'hFFDF, 16'hFFBF, 16'hFF7F};
        do_reset(32'h0000_0123);
        blank_lz = 1'b1;
        en = 1'b1;
        collect(8);
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (got[k] !== exp_w[k]) begin
                fails++; $display("FAIL blank_word[%0d]: got %h expected %h", k, got[k], exp_w[k]);
            end
        end
        stop_scan();
        do_reset(32'h0000_0000);
        blank_lz = 1'b1;
        en = 1'b1;
        collect(2);
        tests++;
        if (got[0] !== 16'hC0FE) begin
            fails++; $display("FAIL blank_zero_digit0: got %h expected c0fe", got[0]);
        end
        tests++;
        if (got[1] !== 16'hFFFD) begin
            fails++; $display("FAIL blank_zero_digit1: got %h expected fffd", got[1]);
        end
        stop_scan();
    endtask

    task automatic test_stall();
        do_reset(32'h0000_0123);
        tx_bus.tx_ready = 1'b0;
        en = 1'b1;
        tick(2);
        for (int c = 1; c <= 10; c++) begin
            tests++;
            if (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== 16'hB0FE) begin
                fails++;
                $display("FAIL stall_hold[%0d]: valid=%b data=%h expected valid=1 data=b0fe",
                         c, tx_bus.tx_valid, tx_bus.tx_data);
            end
            tick(1);
        end
        tests++;
        if (tx_bus.tx_valid !== 1'b1) begin
            fails++; $display("FAIL stall_cycle11_valid: got %b expected 1", tx_bus.tx_valid);
        end
        tx_bus.tx_ready = 1'b1;
        tick(1);
        tests++;
        if (tx_bus.tx_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL stall_cycle12: valid=%b busy=%b expected valid=0 busy=1", tx_bus.tx_valid, busy);
        end
        stop_scan();
    endtask

    task automatic test_shadow();
        logic [15:0] exp_w [13] = '{16'hC0F7, 16'hC0EF, 16'hC0DF, 16'hC0BF, 16'hC07F,
                                    16'h90FE, 16'h90FD, 16'h90FB, 16'h90F7, 16'h90EF,
                                    16'h90DF, 16'h90BF, 16'h907F};
        do_reset(32'h0000_0123);
        en = 1'b1;
        collect(3);
        data_bcd = 32'h9999_9999;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        collect(13);
        for (int k = 0; k < 13; k++) begin
            tests++;
            if (got[k] !== exp_w[k]) begin
                fails++; $display("FAIL shadow_word[%0d]: got %h expected %h", k, got[k], exp_w[k]);
            end
        end
        stop_scan();
    endtask

    task automatic test_dash_and_reset();
        do_reset(32'h0000_0A05);
        en = 1'b1;
        collect(3);
        tests++;
        if (got[0] !== 16'h92FE) begin
            fails++; $display("FAIL dash_digit0: got %h expected 92fe", got[0]);
        end
        tests++;
        if (got[2] !== 16'hBFFB) begin
            fails++; $display("FAIL dash_digit2: got %h expected bffb", got[2]);
        end
        tx_bus.tx_ready = 1'b0;
        wait_valid("midsend_reset");
        reset = 1'b1;
        tick(1);
        tests++;
        if (tx_bus.tx_valid !== 1'b0 || tx_bus.tx_data !== 16'hFFFF || busy !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL midsend_reset: valid=%b data=%h busy=%b fd=%b expected 0 ffff 0 0",
                     tx_bus.tx_valid, tx_bus.tx_data, busy, frame_done);
        end
        reset = 1'b0;
        tx_bus.tx_ready = 1'b1;
        collect(1);
        tests++;
        if (got[0] !== 16'hC0FE) begin
            fails++; $display("FAIL reset_clears_shadow: got %h expected c0fe", got[0]);
        end
        stop_scan();
    endtask

    task automatic test_disable();
        do_reset(32'h0000_0123);
        en = 1'b1;
        collect(2);
        tx_bus.tx_ready = 1'b0;
        wait_valid("disable");
        en = 1'b0;
        tick(3);
        tests++;
        if (tx_bus.tx_valid !== 1'b1 || tx_bus.tx_data !== 16'hF9FB) begin
            fails++;
            $display("FAIL disable_pending: valid=%b data=%h expected 1 f9fb", tx_bus.tx_valid, tx_bus.tx_data);
        end
        tx_bus.tx_ready = 1'b1;
        tick(1);
        tests++;
        if (tx_bus.tx_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL disable_handshake: valid=%b busy=%b expected 0 1", tx_bus.tx_valid, busy);
        end
        tick(3);
        tests++;
        if (busy !== 1'b1) begin
            fails++; $display("FAIL disable_dwell: busy=%b expected 1", busy);
        end
        tick(1);
        tests++;
        if (busy !== 1'b0) begin
            fails++; $display("FAIL disable_idle: busy=%b expected 0", busy);
        end
        tick(3);
        tests++;
        if (busy !== 1'b0 || tx_bus.tx_valid !== 1'b0) begin
            fails++; $display("FAIL disable_stays_idle: busy=%b valid=%b expected 0 0", busy, tx_bus.tx_valid);
        end
        en = 1'b1;
        collect(1);
        tests++;
        if (got[0] !== 16'hC0F7) begin
            fails++; $display("FAIL disable_resume_word: got %h expected c0f7", got[0]);
        end
        tests++;
        if (at[0] !== 2) begin
            fails++; $display("FAIL disable_resume_latency: got %0d expected 2", at[0]);
        end
        stop_scan();
    endtask

    initial begin
        tx_bus.tx_ready = 1'b1;
        test_reset();
        test_basic();
        test_blank_lz();
        test_stall();
        test_shadow();
        test_dash_and_reset();
        test_disable();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
